// File: rtl/range_finder_multi_if.sv
// Bundle between the multi-echo range counter and its sensor / downstream side.
// meas_valid rises when a shot result is ready and stays high, with the result
// stable, until a cycle where meas_ready is also high; the transfer happens in
// that cycle and meas_valid drops on the following edge.
interface range_finder_multi_if #(
  parameter int WIDTH  = 8,
  parameter int N_ECHO = 4
);
  localparam int CW = $clog2(N_ECHO + 1);

  logic                    em_sensor;
  logic                    rec_sensor;
  logic [WIDTH-1:0]        min_range;
  logic [WIDTH-1:0]        max_range;
  logic [N_ECHO*WIDTH-1:0] echo_range;
  logic [CW-1:0]           echo_cnt;
  logic                    no_echo;
  logic                    meas_valid;
  logic                    meas_ready;
  logic                    busy;
  logic                    shot_drop;

  modport master (
    output em_sensor, rec_sensor, min_range, max_range, meas_ready,
    input  echo_range, echo_cnt, no_echo, meas_valid, busy, shot_drop
  );

  modport slave (
    input  em_sensor, rec_sensor, min_range, max_range, meas_ready,
    output echo_range, echo_cnt, no_echo, meas_valid, busy, shot_drop
  );
endinterface

// File: rtl/range_finder_multi.sv
// Multi-echo laser range counter: synchronises em/rec sensor pins, counts from
// the em edge and captures up to N_ECHO rec edges per shot, then holds the result.
module range_finder_multi #(
  parameter int WIDTH       = 8,
  parameter int N_ECHO      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  range_finder_multi_if.slave    bus,
  output logic [1:0]             state_dbg
);
  localparam int CW = $clog2(N_ECHO + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] em_sync, rec_sync;
  logic                   em_q, rec_q, em_p, rec_p;

  logic [WIDTH-1:0] cnt, min_lat, max_lat;
  logic [WIDTH-1:0] slots [N_ECHO];
  logic [CW-1:0]    echo_cnt;
  logic             no_echo;
  logic             cap, last_cap, done;

  // Synchroniser chain, then a registered rising-edge pulse per sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_sync  <= '0;
      rec_sync <= '0;
      em_q     <= 1'b0;
      rec_q    <= 1'b0;
      em_p     <= 1'b0;
      rec_p    <= 1'b0;
    end else begin
      em_sync  <= {em_sync[SYNC_STAGES-2:0], bus.em_sensor};
      rec_sync <= {rec_sync[SYNC_STAGES-2:0], bus.rec_sensor};
      em_q     <= em_sync[SYNC_STAGES-1];
      rec_q    <= rec_sync[SYNC_STAGES-1];
      em_p     <= em_sync[SYNC_STAGES-1] & ~em_q;
      rec_p    <= rec_sync[SYNC_STAGES-1] & ~rec_q;
    end
  end

  always_comb begin
    cap      = (state == COUNT) && rec_p && (cnt >= min_lat) && (echo_cnt < CW'(N_ECHO));
    last_cap = cap && (echo_cnt == CW'(N_ECHO - 1));
    done     = (state == COUNT) && ((cnt == max_lat) || last_cap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (em_p) state_nxt = COUNT;
      COUNT:   if (done) state_nxt = HOLD;
      HOLD:    if (bus.meas_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    state_dbg      = state;
    bus.busy       = (state != IDLE);
    bus.meas_valid = (state == HOLD);
    bus.shot_drop  = em_p && (state != IDLE);
  end

  // cnt stops on the exit cycle, so it never wraps past max_lat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      min_lat  <= '0;
      max_lat  <= '0;
      echo_cnt <= '0;
      no_echo  <= 1'b0;
      for (int i = 0; i < N_ECHO; i++) slots[i] <= '0;
    end else if (state == IDLE) begin
      if (em_p) begin
        cnt      <= WIDTH'(1);
        min_lat  <= bus.min_range;
        max_lat  <= (bus.max_range == '0) ? '1 : bus.max_range;
        echo_cnt <= '0;
        no_echo  <= 1'b0;
        for (int i = 0; i < N_ECHO; i++) slots[i] <= '0;
      end
    end else if (state == COUNT) begin
      if (cap) begin
        for (int i = 0; i < N_ECHO; i++) begin
          if (echo_cnt == CW'(i)) slots[i] <= cnt;
        end
        echo_cnt <= echo_cnt + CW'(1);
      end
      if (done) begin
        no_echo <= (echo_cnt == '0) && !cap;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

  always_comb begin
    bus.echo_range = '0;
    for (int i = 0; i < N_ECHO; i++) bus.echo_range[i*WIDTH +: WIDTH] = slots[i];
    bus.echo_cnt = echo_cnt;
    bus.no_echo  = no_echo;
  end
endmodule

// File: tb/tb_range_finder_multi.sv
// Bench for range_finder_multi: directed shot table, reset/backpressure
// sequences and randomized shots against an echo-list reference model.
module tb_range_finder_multi;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int CW = $clog2(N + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  range_finder_multi_if #(.WIDTH(W), .N_ECHO(N)) bus ();

  range_finder_multi #(.WIDTH(W), .N_ECHO(N), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int             nd;
    logic [5:0][7:0] d;
    int             mn;
    int             mx;
    int             e_cnt;
    logic [N*W-1:0] e_rng;
    bit             e_no;
    int             e_end;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(int nd, logic [5:0][7:0] d, int mn, int mx, int ec,
                              logic [N*W-1:0] er, bit eno, int eend);
    vec_t v;
    v.nd = nd; v.d = d; v.mn = mn; v.mx = mx;
    v.e_cnt = ec; v.e_rng = er; v.e_no = eno; v.e_end = eend;
    return v;
  endfunction

  function automatic bit rec_at(int nd, logic [5:0][7:0] d, int c);
    for (int k = 0; k < nd; k++) if (int'(d[k]) == c) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: echoes are the delays inside [max(1,min), limit], first N of them;
  // the shot ends at the N-th echo or at the limit.
  task automatic model(input int nd, input logic [5:0][7:0] d, input int mn, input int mx,
                       output int e_end);
    int lim;
    lim = (mx == 0) ? 255 : mx;
    e_end = lim;
    exp_q.delete();
    for (int k = 0; k < nd; k++) begin
      int dk;
      dk = int'(d[k]);
      if (dk >= 1 && dk >= mn && dk <= lim && exp_q.size() < N) begin
        exp_q.push_back(W'(dk));
        if (exp_q.size() == N) e_end = dk;
      end
    end
  endtask

  task automatic tick(inout int drops);
    @(posedge clk); #1;
    if (bus.shot_drop) drops++;
  endtask

  // Drives one shot from the em pin edge (c=0); rec pin high for one cycle at each delay.
  task automatic run_shot(input int nd, input logic [5:0][7:0] d, input int mn, input int mx,
                          input int hold_n, input bit refire,
                          output logic [N*W-1:0] rng, output int ecnt, output bit eno,
                          output int vcyc, output int bcyc, output int drops);
    drops = 0; bcyc = -1; vcyc = -1;
    bus.min_range  = W'(mn);
    bus.max_range  = W'(mx);
    bus.em_sensor  = 1'b1;
    bus.rec_sensor = rec_at(nd, d, 0);
    for (int c = 1; c <= 300; c++) begin
      tick(drops);
      if (bus.busy && bcyc < 0) bcyc = c;
      if (bus.meas_valid) begin
        vcyc = c;
        break;
      end
      bus.em_sensor  = (c < 3);
      bus.rec_sensor = rec_at(nd, d, c);
      if (c >= S + 2) begin
        bus.min_range = W'($urandom_range(0, 255));
        bus.max_range = W'($urandom_range(0, 255));
      end
    end
    check("shot_reaches_valid", 64'(vcyc > 0), 64'd1);
    bus.em_sensor  = 1'b0;
    bus.rec_sensor = 1'b0;
    rng  = bus.echo_range;
    ecnt = int'(bus.echo_cnt);
    eno  = bus.no_echo;
    for (int h = 0; h < hold_n; h++) begin
      bus.em_sensor = refire && (h >= 2) && (h < 5);
      tick(drops);
      check("hold_stable", {bus.meas_valid, bus.no_echo, bus.echo_cnt, bus.echo_range},
            {1'b1, eno, CW'(ecnt), rng});
    end
    bus.em_sensor  = 1'b0;
    bus.meas_ready = 1'b1;
    tick(drops);
    bus.meas_ready = 1'b0;
    check("idle_after_ready", {bus.busy, bus.meas_valid}, 2'b00);
    repeat (8) tick(drops);
  endtask

  task automatic shot_and_check(input string tag, input int nd, input logic [5:0][7:0] d,
                                input int mn, input int mx, input int hold_n, input bit refire,
                                input int e_cnt, input logic [N*W-1:0] e_rng, input bit e_no,
                                input int e_end, input int e_drops);
    logic [N*W-1:0] rng;
    int ecnt, vcyc, bcyc, drops;
    bit eno;
    run_shot(nd, d, mn, mx, hold_n, refire, rng, ecnt, eno, vcyc, bcyc, drops);
    check({tag, "_echo_cnt"}, 64'(ecnt), 64'(e_cnt));
    check({tag, "_echo_range"}, 64'(rng), 64'(e_rng));
    check({tag, "_no_echo"}, 64'(eno), 64'(e_no));
    check({tag, "_valid_cycle"}, 64'(vcyc), 64'(e_end + S + 2));
    check({tag, "_busy_latency"}, 64'(bcyc), 64'(S + 2));
    check({tag, "_drops"}, 64'(drops), 64'(e_drops));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_end, drops;
    logic [5:0][7:0] d;
    logic [N*W-1:0] e_rng;

    bus.em_sensor = 1'b0; bus.rec_sensor = 1'b0;
    bus.min_range = '0;   bus.max_range = '0;
    bus.meas_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.echo_range, bus.echo_cnt, bus.no_echo, bus.meas_valid,
                            bus.busy, bus.shot_drop}, '0);
    check("reset_state", 64'(state_dbg), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    vecs.push_back(mk(1, {40'd0, 8'd37}, 0, 200, 1, {24'd0, 8'd37}, 0, 200));
    vecs.push_back(mk(5, {8'd0, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 0, 200, 4,
                      {8'd40, 8'd30, 8'd20, 8'd10}, 0, 40));
    vecs.push_back(mk(2, {32'd0, 8'd25, 8'd5}, 15, 200, 1, {24'd0, 8'd25}, 0, 200));
    vecs.push_back(mk(0, 48'd0, 0, 50, 0, '0, 1, 50));
    vecs.push_back(mk(0, 48'd0, 0, 0, 0, '0, 1, 255));
    vecs.push_back(mk(2, {32'd0, 8'd20, 8'd10}, 30, 25, 0, '0, 1, 25));
    vecs.push_back(mk(1, {40'd0, 8'd60}, 0, 60, 1, {24'd0, 8'd60}, 0, 60));
    vecs.push_back(mk(1, {40'd0, 8'd14}, 15, 100, 0, '0, 1, 100));
    vecs.push_back(mk(1, {40'd0, 8'd15}, 15, 100, 1, {24'd0, 8'd15}, 0, 100));
    vecs.push_back(mk(2, {32'd0, 8'd3, 8'd0}, 0, 10, 1, {24'd0, 8'd3}, 0, 10));
    vecs.push_back(mk(1, {40'd0, 8'd1}, 0, 10, 1, {24'd0, 8'd1}, 0, 10));
    vecs.push_back(mk(4, {16'd0, 8'd30, 8'd20, 8'd10, 8'd5}, 0, 30, 4,
                      {8'd30, 8'd20, 8'd10, 8'd5}, 0, 30));

    foreach (vecs[i]) begin
      shot_and_check($sformatf("vec%0d", i), vecs[i].nd, vecs[i].d, vecs[i].mn, vecs[i].mx,
                     int'($urandom_range(0, 3)), 1'b0, vecs[i].e_cnt, vecs[i].e_rng,
                     vecs[i].e_no, vecs[i].e_end, 0);
    end

    // Backpressure for 20 cycles while em re-fires: one drop, result held.
    shot_and_check("backpressure", 1, {40'd0, 8'd37}, 0, 60, 20, 1'b1,
                   1, {24'd0, 8'd37}, 0, 60, 1);

    // Reset in the middle of a shot after two echoes.
    drops = 0;
    bus.min_range = '0; bus.max_range = W'(200);
    bus.em_sensor = 1'b1; bus.rec_sensor = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick(drops);
      bus.em_sensor  = (c < 3);
      bus.rec_sensor = (c == 10) || (c == 20);
    end
    check("midshot_busy", 64'(bus.busy), 64'd1);
    check("midshot_echo_cnt", 64'(bus.echo_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    check("midshot_reset_outputs", {bus.echo_range, bus.echo_cnt, bus.no_echo, bus.meas_valid,
                                    bus.busy, bus.shot_drop}, '0);
    check("midshot_reset_state", 64'(state_dbg), 64'd0);
    bus.em_sensor = 1'b0; bus.rec_sensor = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    shot_and_check("after_reset", 1, {40'd0, 8'd7}, 0, 100, 1, 1'b0,
                   1, {24'd0, 8'd7}, 0, 100, 0);

    // Randomized shots against the reference model.
    for (int r = 0; r < 40; r++) begin
      int nd, t, mn, mx;
      nd = $urandom_range(0, 6);
      t  = $urandom_range(0, 20);
      d  = '0;
      for (int k = 0; k < 6; k++) begin
        if (k < nd) begin
          if (t > 255) begin
            nd = k;
          end else begin
            d[k] = 8'(t);
            t = t + $urandom_range(2, 50);
          end
        end
      end
      mn = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 60);
      mx = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 200);
      model(nd, d, mn, mx, e_end);
      e_rng = '0;
      for (int i = 0; i < N; i++) begin
        if (exp_q.size() > 0) e_rng[i*W +: W] = exp_q[i];
      end
      shot_and_check($sformatf("rand%0d", r), nd, d, mn, mx, int'($urandom_range(0, 3)), 1'b0,
                     exp_q.size(), e_rng, exp_q.size() == 0, e_end, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
